tan_req_scheduler: RTL and testbench
====================================

Name: tan_req_scheduler

Overview:
- Shares one free-running tan core among N_REQ requesters.
- The tan core has ports clk, rst_n, xita[31:0], tan[31:0] and valid; angles are signed Q16.16 degrees.
- The block arbitrates requests round-robin and drives the core's xita. It waits out the core's iteration latency, captures the core's tan output and returns it to the granted requester with a one-cycle response pulse.
- It rejects angles at or beyond ±90° without using the core. It sits between the control logic and the shared core at top level.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MIN_WAIT, 18, cycles after loading xita before core valid is trusted; this covers the core's iterations plus the stale-valid window.
- TIMEOUT, 64, cycles in WAIT after which the transaction aborts with error; must be > MIN_WAIT.
- ANGLE_LIM, 32'h005A_0000, 90.0° in Q16.16; inputs with |xita| >= ANGLE_LIM are rejected.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  request per requester; level, held until that requester's resp_valid bit pulses.
- req_xita  in  32*N_REQ  angle per requester; slice i is bits [32i+31:32i]; must be stable while req[i]=1.
- resp_valid  out  N_REQ  one-hot, one-cycle pulse to the completed requester.
- resp_tan  out  32  result (Q16.16); valid only while resp_valid != 0.
- resp_err  out  1  qualifies resp_valid: 1 = out-of-range angle or timeout, with resp_tan = 0.
- busy  out  1  high in WAIT and RESP.
- core_xita  out  32  registered angle to the tan core; holds its value between transactions.
- core_valid  in  1  tan core valid.
- core_tan  in  32  tan core result.

Behaviour:
- Reset (async, rst_n=0): all outputs are 0, state is IDLE, the round-robin pointer is 0 and the counter is 0. A reset mid-transaction abandons the transaction and produces no response.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If req != 0, grant the first set bit at or after the pointer, searching upward with wrap-around.
  - Latch the grant index g.
  - If the angle is in range (signed x < ANGLE_LIM and x > -ANGLE_LIM), load core_xita <= req_xita[g], clear the counter and go to WAIT.
  - Otherwise leave core_xita unchanged, set err and go to RESP.
  - 32'h8000_0000 is out of range.
- WAIT:
  - The counter increments every cycle.
  - core_valid is ignored while counter < MIN_WAIT.
  - Once counter >= MIN_WAIT and core_valid=1, capture core_tan and go to RESP.
  - If counter reaches TIMEOUT-1 without capture, set err and go to RESP.
  - Capture takes priority when both conditions occur in the same cycle.
- RESP:
  - Drive resp_valid[g]=1 and resp_tan/resp_err for exactly one cycle.
  - Set the pointer to (g+1) mod N_REQ and return to IDLE.
  - The next request can be sampled at the following edge, so back-to-back transactions have one idle cycle between them.
- Latency:
  - In range: resp_valid rises at least MIN_WAIT+2 edges after the sampling edge, exactly MIN_WAIT+2 if core_valid is already high.
  - Out of range: resp_valid rises 1 edge after the sampling edge.
- Requester protocol:
  - A requester may keep req high after its response; this is treated as a new request and competes round-robin.
  - Deasserting req while granted has no effect on the current transaction; it still completes.
  - req_xita is sampled only in IDLE on the grant edge.
- Fairness: with all requesters active, each waits at most N_REQ-1 transactions.
- resp_tan and resp_err are registered outputs; resp_tan is forced to 0 outside RESP.

Decomposition:
- Shared package holds:
  - Q16.16 angle constants: ANGLE_LIM, DEG_30 = 32'h001E_0000, DEG_45 = 32'h002D_0000, DEG_60 = 32'h003C_0000.
  - FSM state encoding: IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2.
- One sub-module: rr_arbiter, parameterised on N_REQ.
  - Inputs: req, pointer.
  - Outputs: one-hot grant, grant index, any.
  - Purely combinational, reusable by other shared-resource schedulers.
- The tan core is instantiated at top level, not inside this block.

Test Plan:
- Single request: req[0]=1, req_xita0=32'h001E_0000 (30°); core model raises valid 20 cycles after xita changes, with tan=32'h0000_93CD. Expect core_xita=32'h001E_0000 on the edge after the request, then resp_valid=4'b0001, resp_tan=32'h0000_93CD, resp_err=0.
- Stale valid: core_valid held high throughout; 45° request. Expect the response exactly MIN_WAIT+2 edges after the sampling edge, never earlier; resp_tan equals the core output at capture (32'h0001_0000).
- Contention: req=4'b1111 held with angles 0°, 30°, 45°, 60°. Expect responses in order 0, 1, 2, 3, 0, each separated by one IDLE cycle. Then req=4'b0101 right after index 0 is served: expect 2 next, then 0.
- Out of range: req[1] with 32'h005A_0000, then with 32'hFFA6_0000 (-90°). Expect resp_valid=4'b0010, resp_err=1, resp_tan=0 one edge after sampling each time; core_xita unchanged.
- Timeout: core_valid stuck at 0, req[2] with 60°. Expect resp_valid=4'b0100 with resp_err=1 after TIMEOUT cycles in WAIT; busy then drops.
- Reset mid-operation: assert rst_n=0 ten cycles into WAIT. Expect all outputs immediately 0 and no response pulse. After release, a fresh 30° request completes normally, starting arbitration from pointer 0.

Source files
------------

// File: rtl/tan_req_scheduler_pkg.sv
// Shared constants and state encoding for the tan request scheduler.
package tan_req_scheduler_pkg;

    // Q16.16 angle constants in degrees
    localparam logic [31:0] ANGLE_LIM = 32'h005A_0000;
    localparam logic [31:0] DEG_30    = 32'h001E_0000;
    localparam logic [31:0] DEG_45    = 32'h002D_0000;
    localparam logic [31:0] DEG_60    = 32'h003C_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after
// the pointer, searching upward with wrap-around.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] pointer,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            idx = IDX_W'((int'(pointer) + i) % int'(N_REQ));
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant_idx  = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tan_req_scheduler.sv
// Shares one free-running tan core among N_REQ requesters: round-robin grant,
// range check, settle/timeout wait, then a one-cycle response pulse.
module tan_req_scheduler #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned MIN_WAIT  = 18,
    parameter int unsigned TIMEOUT   = 64,
    parameter logic [31:0] ANGLE_LIM = 32'h005A_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [32*N_REQ-1:0]   req_xita,
    output logic [N_REQ-1:0]      resp_valid,
    output logic [31:0]           resp_tan,
    output logic                  resp_err,
    output logic                  busy,
    output logic [31:0]           core_xita,
    input  logic                  core_valid,
    input  logic [31:0]           core_tan
);
    import tan_req_scheduler_pkg::*;

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [N_REQ-1:0] gnt_onehot;
    logic [CNT_W-1:0] cnt;
    logic             err;
    logic [31:0]      tan_q;

    logic [N_REQ-1:0] grant_c;
    logic [IDX_W-1:0] grant_idx_c;
    logic             any_c;
    logic [31:0]      xita_arr [N_REQ];
    logic [31:0]      sel_xita_c;
    logic             in_range_c;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req       (req),
        .pointer   (ptr),
        .grant     (grant_c),
        .grant_idx (grant_idx_c),
        .any       (any_c)
    );

    for (genvar gi = 0; gi < int'(N_REQ); gi++) begin : g_slice
        assign xita_arr[gi] = req_xita[gi*32 +: 32];
    end

    assign sel_xita_c = xita_arr[grant_idx_c];

    // Strict bounds on both sides, so the most negative value is also rejected
    assign in_range_c = ($signed(sel_xita_c) < $signed(ANGLE_LIM)) &&
                        ($signed(sel_xita_c) > -$signed(ANGLE_LIM));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            gnt_idx    <= '0;
            gnt_onehot <= '0;
            cnt        <= '0;
            err        <= 1'b0;
            tan_q      <= '0;
            core_xita  <= '0;
            resp_valid <= '0;
            resp_tan   <= '0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            resp_valid <= '0;
            resp_tan   <= '0;
            resp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_c) begin
                        gnt_idx    <= grant_idx_c;
                        gnt_onehot <= grant_c;
                        busy       <= 1'b1;
                        if (in_range_c) begin
                            core_xita <= sel_xita_c;
                            cnt       <= '0;
                            err       <= 1'b0;
                            state     <= WAIT;
                        end else begin
                            err   <= 1'b1;
                            tan_q <= '0;
                            state <= RESP;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // Valid before MIN_WAIT may belong to the previous angle
                    if (cnt >= CNT_W'(MIN_WAIT) && core_valid) begin
                        tan_q <= core_tan;
                        err   <= 1'b0;
                        state <= RESP;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        tan_q <= '0;
                        err   <= 1'b1;
                        state <= RESP;
                    end
                end
                RESP: begin
                    resp_valid <= gnt_onehot;
                    resp_tan   <= err ? 32'h0 : tan_q;
                    resp_err   <= err;
                    ptr        <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tan_req_scheduler.sv
// Directed and randomized bench for tan_req_scheduler with a simple tan core model.
module tb_tan_req_scheduler;
    import tan_req_scheduler_pkg::*;

    localparam int unsigned N        = 4;
    localparam int unsigned MIN_WAIT = 18;
    localparam int unsigned TIMEOUT  = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [32*N-1:0] req_xita;
    logic [N-1:0]    resp_valid;
    logic [31:0]     resp_tan;
    logic            resp_err;
    logic            busy;
    logic [31:0]     core_xita;
    logic            core_valid;
    logic [31:0]     core_tan;

    int errors = 0;
    int checks = 0;

    // Core model: 0 = valid after lat cycles of stable xita, 1 = stuck high, 2 = stuck low
    int          core_mode = 0;
    int          lat = 20;
    int          age = 0;
    logic [31:0] last_x = '0;

    always #5 clk = ~clk;

    tan_req_scheduler #(
        .N_REQ(N), .MIN_WAIT(MIN_WAIT), .TIMEOUT(TIMEOUT), .ANGLE_LIM(ANGLE_LIM)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_xita   (req_xita),
        .resp_valid (resp_valid),
        .resp_tan   (resp_tan),
        .resp_err   (resp_err),
        .busy       (busy),
        .core_xita  (core_xita),
        .core_valid (core_valid),
        .core_tan   (core_tan)
    );

    function automatic logic [31:0] core_fn(input logic [31:0] x);
        case (x)
            32'h0:   return 32'h0;
            DEG_30:  return 32'h0000_93CD;
            DEG_45:  return 32'h0001_0000;
            DEG_60:  return 32'h0001_BB68;
            default: return x ^ 32'h3C3C_A5A5;
        endcase
    endfunction

    always @(posedge clk) begin
        if (core_xita !== last_x) begin
            last_x <= core_xita;
            age    <= 0;
        end else if (age < 1000) begin
            age <= age + 1;
        end
    end

    assign core_tan   = core_fn(core_xita);
    assign core_valid = (core_mode == 1) ||
                        (core_mode == 0 && core_xita === last_x && age >= lat);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_x(input int i, input logic [31:0] v);
        req_xita[32*i +: 32] = v;
    endtask

    // Waits (bounded) for the next response pulse; edges = posedges waited
    task automatic wait_resp(input string tag, output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (resp_valid === '0 && edges < 200);
        chk({tag, "_seen"}, {31'b0, (resp_valid !== '0)}, 32'h1);
    endtask

    // Expected response from the angle rules, using plain integer arithmetic
    task automatic check_resp(input string tag, input int g, input logic [31:0] x, input logic to);
        longint v;
        logic   in_rng;
        logic   exp_err;
        v       = longint'($signed(x));
        in_rng  = (v < 64'sd5898240) && (v > -64'sd5898240);
        exp_err = !in_rng || to;
        chk({tag, "_valid"}, 32'(resp_valid), 32'(1) << g);
        chk({tag, "_err"},   32'(resp_err),   32'(exp_err));
        chk({tag, "_tan"},   resp_tan,        exp_err ? 32'h0 : core_fn(x));
    endtask

    function automatic int rr_pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < int'(N); k++)
            if (m[(p + k) % int'(N)]) return (p + k) % int'(N);
        return -1;
    endfunction

    function automatic logic [31:0] pick_angle();
        case ($urandom_range(0, 9))
            0:       return 32'h0;
            1:       return DEG_30;
            2:       return DEG_45;
            3:       return DEG_60;
            4:       return -DEG_30;
            5:       return ANGLE_LIM;
            6:       return 32'hFFA6_0000;
            7:       return 32'h8000_0000;
            8:       return ANGLE_LIM - 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          e;
        int          g;
        int          ptr_m;
        int          extra;
        int          order [5];
        logic [31:0] ang [N];
        logic [31:0] t3_ang [N];
        logic [N-1:0] m;

        rst_n = 1'b0;
        req = '0;
        req_xita = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_tan", resp_tan, 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_core_xita", core_xita, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request, core valid 20 cycles after xita changes
        core_mode = 0; lat = 20;
        set_x(0, DEG_30); req = 4'b0001;
        @(posedge clk); #1;
        chk("t1_core_xita", core_xita, DEG_30);
        chk("t1_busy", 32'(busy), 32'h1);
        wait_resp("t1", e);
        check_resp("t1", 0, DEG_30, 1'b0);
        chk("t1_lat_min", 32'(e >= int'(MIN_WAIT) + 2), 32'h1);
        req = '0;

        // Stale valid held high
        core_mode = 1;
        set_x(3, DEG_45); req = 4'b1000;
        @(posedge clk); #1;
        wait_resp("t2", e);
        check_resp("t2", 3, DEG_45, 1'b0);
        chk("t2_lat", 32'(e), 32'(MIN_WAIT + 2));
        req = '0;

        // Contention, all four requesters held
        core_mode = 0; lat = 20;
        t3_ang[0] = 32'h0; t3_ang[1] = DEG_30; t3_ang[2] = DEG_45; t3_ang[3] = DEG_60;
        for (int i = 0; i < int'(N); i++) set_x(i, t3_ang[i]);
        req = 4'b1111;
        order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            wait_resp($sformatf("t3_%0d", k), e);
            check_resp($sformatf("t3_%0d", k), order[k], t3_ang[order[k]], 1'b0);
        end
        req = 4'b0101;
        wait_resp("t3_b", e);
        check_resp("t3_b", 2, DEG_45, 1'b0);
        req = 4'b0001;
        wait_resp("t3_c", e);
        check_resp("t3_c", 0, 32'h0, 1'b0);
        req = '0;

        // Out of range: +90, -90, most negative
        set_x(1, ANGLE_LIM); req = 4'b0010;
        @(posedge clk); #1;
        wait_resp("t4a", e);
        check_resp("t4a", 1, ANGLE_LIM, 1'b0);
        chk("t4a_lat", 32'(e), 32'h1);
        chk("t4a_core_xita", core_xita, 32'h0);
        set_x(1, 32'hFFA6_0000);
        @(posedge clk); #1;
        wait_resp("t4b", e);
        check_resp("t4b", 1, 32'hFFA6_0000, 1'b0);
        chk("t4b_lat", 32'(e), 32'h1);
        chk("t4b_core_xita", core_xita, 32'h0);
        set_x(1, 32'h8000_0000);
        @(posedge clk); #1;
        wait_resp("t4c", e);
        check_resp("t4c", 1, 32'h8000_0000, 1'b0);
        req = '0;

        // Timeout with core valid stuck low; req dropped while granted
        core_mode = 2;
        set_x(2, DEG_60); req = 4'b0100;
        @(posedge clk); #1;
        req = '0;
        chk("t5_busy_wait", 32'(busy), 32'h1);
        wait_resp("t5", e);
        check_resp("t5", 2, DEG_60, 1'b1);
        chk("t5_lat", 32'(e), 32'(TIMEOUT + 1));
        @(posedge clk); #1;
        chk("t5_busy_drop", 32'(busy), 32'h0);

        // Reset ten cycles into WAIT
        core_mode = 0; lat = 20;
        set_x(0, DEG_30); req = 4'b0001;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        chk("t6_busy_pre", 32'(busy), 32'h1);
        rst_n = 1'b0; req = '0;
        #1;
        chk("t6_resp_valid", 32'(resp_valid), 32'h0);
        chk("t6_resp_tan", resp_tan, 32'h0);
        chk("t6_resp_err", 32'(resp_err), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_core_xita", core_xita, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("t6_no_resp", 32'(resp_valid), 32'h0);
        end
        rst_n = 1'b1;
        set_x(0, DEG_30); set_x(3, DEG_30); req = 4'b1001;
        @(posedge clk); #1;
        wait_resp("t6_post0", e);
        check_resp("t6_post0", 0, DEG_30, 1'b0);
        req = 4'b1000;
        wait_resp("t6_post3", e);
        check_resp("t6_post3", 3, DEG_30, 1'b0);
        req = '0;
        ptr_m = 0;

        // Randomized rounds against the round-robin reference
        for (int r = 0; r < 25; r++) begin
            core_mode = 0;
            lat = $urandom_range(0, 40);
            m = N'($urandom_range(1, 15));
            for (int i = 0; i < int'(N); i++) begin
                ang[i] = pick_angle();
                set_x(i, ang[i]);
            end
            req = m;
            extra = 0;
            while (m != '0) begin
                g = rr_pick(m, ptr_m);
                wait_resp($sformatf("rnd%0d", r), e);
                if (e >= 200) break;
                check_resp($sformatf("rnd%0d", r), g, ang[g], 1'b0);
                ptr_m = (g + 1) % int'(N);
                if (extra < 4 && $urandom_range(0, 2) == 0) begin
                    ang[g] = pick_angle();
                    set_x(g, ang[g]);
                    extra++;
                end else begin
                    m[g] = 1'b0;
                end
                req = m;
            end
            req = '0;
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
